// File: rtl/freq_gate_bcd_sequencer.sv
`timescale 1ns/1ps
// Frequency-meter sequencer: gate window, synchronized edge counting, and 28-step double-dabble to six BCD digits.
// Optional leading-zero blanking output is enabled by defining FREQ_BLANK_LZ_EN.
module freq_gate_bcd_sequencer #(
    parameter int GATE_CYCLES = 50_000_000,
    parameter int BIN_W       = 28,
    parameter int DIGITS      = 6
) (
    input  logic                clk,
    input  logic                rst_a_n,
    input  logic                run,
    input  logic                sample_signal,
    output logic [BIN_W-1:0]    hz,
    output logic [4*DIGITS-1:0] bcd,
    output logic                valid,
    output logic                busy,
    output logic                overflow
`ifdef FREQ_BLANK_LZ_EN
    ,
    output logic [DIGITS-1:0]   blank
`endif
);

    localparam int GCW   = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam int SCW   = $clog2(BIN_W);
    localparam int BCD_W = 4 * DIGITS;
    localparam int SH_W  = BCD_W + BIN_W;

    localparam logic [GCW-1:0]   GATE_LAST  = GCW'(GATE_CYCLES - 1);
    localparam logic [SCW-1:0]   SHIFT_LAST = SCW'(BIN_W - 1);
    localparam logic [BIN_W-1:0] CNT_MAX    = {BIN_W{1'b1}};
    localparam logic [BIN_W-1:0] OVF_LIMIT  = BIN_W'(32'd1_000_000);

    typedef enum logic {IDLE = 1'b0, GATE = 1'b1} gate_state_t;
    typedef enum logic [1:0] {C_IDLE = 2'd0, C_SHIFT = 2'd1, C_DONE = 2'd2} conv_state_t;

    function automatic logic [BCD_W-1:0] add3_nibbles(input logic [BCD_W-1:0] d);
        logic [BCD_W-1:0] r;
        r = d;
        for (int i = 0; i < DIGITS; i++) begin
            if (d[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = d[4*i +: 4] + 4'd3;
            end else begin
                r[4*i +: 4] = d[4*i +: 4];
            end
        end
        return r;
    endfunction

`ifdef FREQ_BLANK_LZ_EN
    // Digit i blanks only while it and every digit above it are zero; units always shows.
    function automatic logic [DIGITS-1:0] lz_blank(input logic [BCD_W-1:0] d);
        logic [DIGITS-1:0] b;
        logic              hi_zero;
        b       = '0;
        hi_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            hi_zero = hi_zero & (d[4*i +: 4] == 4'd0);
            b[i]    = hi_zero;
        end
        b[0] = 1'b0;
        return b;
    endfunction
`endif

    logic              s1_r, s2_r, s3_r;
    logic              edge_s;
    gate_state_t       gate_state_r, gate_next_s;
    logic              gate_end_s;
    logic [GCW-1:0]    gate_cnt_r;
    logic [BIN_W-1:0]  edge_cnt_r;
    logic [BIN_W-1:0]  final_cnt_s;
    logic [BIN_W-1:0]  hz_r;
    conv_state_t       conv_state_r, conv_next_s;
    logic [SCW-1:0]    shift_cnt_r;
    logic [SH_W-1:0]   shift_r;
    logic [SH_W-1:0]   shift_adj_s;
    logic [SH_W-1:0]   shift_step_s;
    logic [BCD_W-1:0]  bcd_r;
    logic              valid_r;
    logic              busy_r;
    logic              ovf_r;
`ifdef FREQ_BLANK_LZ_EN
    logic [DIGITS-1:0] blank_r;
`endif

    // Two-flop synchronizer plus one delay stage for rising-edge detection.
    always_ff @(posedge clk or negedge rst_a_n) begin
        if (!rst_a_n) begin
            s1_r <= 1'b0;
            s2_r <= 1'b0;
            s3_r <= 1'b0;
        end else begin
            s1_r <= sample_signal;
            s2_r <= s1_r;
            s3_r <= s2_r;
        end
    end

    assign edge_s = s2_r & ~s3_r;

    // Gate FSM next state and terminal-cycle decode; dropping run abandons the window.
    always_comb begin
        gate_next_s = gate_state_r;
        gate_end_s  = 1'b0;
        case (gate_state_r)
            IDLE: begin
                if (run) begin
                    gate_next_s = GATE;
                end else begin
                    gate_next_s = IDLE;
                end
            end
            GATE: begin
                if (!run) begin
                    gate_next_s = IDLE;
                end else begin
                    gate_next_s = GATE;
                    gate_end_s  = (gate_cnt_r == GATE_LAST);
                end
            end
            default: gate_next_s = IDLE;
        endcase
    end

    // Count including the current cycle's edge, saturating at all-ones.
    always_comb begin
        if (edge_s && (edge_cnt_r != CNT_MAX)) begin
            final_cnt_s = edge_cnt_r + BIN_W'(1'b1);
        end else begin
            final_cnt_s = edge_cnt_r;
        end
    end

    // Gate state register.
    always_ff @(posedge clk or negedge rst_a_n) begin
        if (!rst_a_n) begin
            gate_state_r <= IDLE;
        end else begin
            gate_state_r <= gate_next_s;
        end
    end

    // Window counters and hz latch; counters restart without a dead cycle at window end.
    always_ff @(posedge clk or negedge rst_a_n) begin
        if (!rst_a_n) begin
            gate_cnt_r <= '0;
            edge_cnt_r <= '0;
            hz_r       <= '0;
        end else if ((gate_state_r == GATE) && run) begin
            if (gate_end_s) begin
                gate_cnt_r <= '0;
                edge_cnt_r <= '0;
                hz_r       <= final_cnt_s;
            end else begin
                gate_cnt_r <= gate_cnt_r + GCW'(1'b1);
                edge_cnt_r <= final_cnt_s;
            end
        end else begin
            gate_cnt_r <= '0;
            edge_cnt_r <= '0;
        end
    end

    // Conversion FSM next state; once started it always runs to completion.
    always_comb begin
        conv_next_s = conv_state_r;
        case (conv_state_r)
            C_IDLE: begin
                if (gate_end_s) begin
                    conv_next_s = C_SHIFT;
                end else begin
                    conv_next_s = C_IDLE;
                end
            end
            C_SHIFT: begin
                if (shift_cnt_r == SHIFT_LAST) begin
                    conv_next_s = C_DONE;
                end else begin
                    conv_next_s = C_SHIFT;
                end
            end
            C_DONE:  conv_next_s = C_IDLE;
            default: conv_next_s = C_IDLE;
        endcase
    end

    // Conversion state register.
    always_ff @(posedge clk or negedge rst_a_n) begin
        if (!rst_a_n) begin
            conv_state_r <= C_IDLE;
        end else begin
            conv_state_r <= conv_next_s;
        end
    end

    // One double-dabble step: adjust BCD nibbles, then shift the whole scratch left.
    assign shift_adj_s  = {add3_nibbles(shift_r[SH_W-1 -: BCD_W]), shift_r[BIN_W-1:0]};
    assign shift_step_s = shift_adj_s << 1'b1;

    // Conversion datapath and published results.
    always_ff @(posedge clk or negedge rst_a_n) begin
        if (!rst_a_n) begin
            shift_r     <= '0;
            shift_cnt_r <= '0;
            bcd_r       <= '0;
            valid_r     <= 1'b0;
            busy_r      <= 1'b0;
            ovf_r       <= 1'b0;
`ifdef FREQ_BLANK_LZ_EN
            blank_r     <= {{(DIGITS-1){1'b1}}, 1'b0};
`endif
        end else begin
            valid_r <= 1'b0;
            case (conv_state_r)
                C_IDLE: begin
                    if (gate_end_s) begin
                        shift_r     <= {{BCD_W{1'b0}}, final_cnt_s};
                        shift_cnt_r <= '0;
                        busy_r      <= 1'b1;
                    end
                end
                C_SHIFT: begin
                    shift_r     <= shift_step_s;
                    shift_cnt_r <= shift_cnt_r + SCW'(1'b1);
                    if (shift_cnt_r == SHIFT_LAST) begin
                        busy_r  <= 1'b0;
                        valid_r <= 1'b1;
                        if (hz_r >= OVF_LIMIT) begin
                            bcd_r   <= {DIGITS{4'h9}};
                            ovf_r   <= 1'b1;
`ifdef FREQ_BLANK_LZ_EN
                            blank_r <= '0;
`endif
                        end else begin
                            bcd_r   <= shift_step_s[SH_W-1 -: BCD_W];
                            ovf_r   <= 1'b0;
`ifdef FREQ_BLANK_LZ_EN
                            blank_r <= lz_blank(shift_step_s[SH_W-1 -: BCD_W]);
`endif
                        end
                    end
                end
                C_DONE: begin
                    busy_r <= 1'b0;
                end
                default: begin
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign hz       = hz_r;
    assign bcd      = bcd_r;
    assign valid    = valid_r;
    assign busy     = busy_r;
    assign overflow = ovf_r;
`ifdef FREQ_BLANK_LZ_EN
    assign blank    = blank_r;
`endif

endmodule

// File: tb/tb_freq_gate_bcd_sequencer.sv
`timescale 1ns/1ps
// Bench for freq_gate_bcd_sequencer: directed and random pulse trains scored against a per-window
// edge tally converted to decimal digits with plain arithmetic.
module tb_freq_gate_bcd_sequencer;

    localparam int     G       = 100;
    localparam longint CNT_MAX = (64'd1 << 28) - 64'd1;

    logic        clk = 1'b0;
    logic        rst_a_n;
    logic        run;
    logic        sample_signal;
    logic [27:0] hz;
    logic [23:0] bcd;
    logic        valid;
    logic        busy;
    logic        overflow;
`ifdef FREQ_BLANK_LZ_EN
    logic [5:0]  blank;
`endif

    int          checks = 0;
    int          errors = 0;
    int          phase  = 0;
    longint      exp_hz, exp_bcd, exp_ovf, exp_blank;
    longint      cnt [0:7];
    logic [27:0] force_val;

    freq_gate_bcd_sequencer #(.GATE_CYCLES(G)) dut (
        .clk           (clk),
        .rst_a_n       (rst_a_n),
        .run           (run),
        .sample_signal (sample_signal),
        .hz            (hz),
        .bcd           (bcd),
        .valid         (valid),
        .busy          (busy),
        .overflow      (overflow)
`ifdef FREQ_BLANK_LZ_EN
        ,
        .blank         (blank)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic longint sat(input longint v);
        return (v > CNT_MAX) ? CNT_MAX : v;
    endfunction

    function automatic longint to_bcd(input longint v);
        longint r;
        longint x;
        if (v >= 1000000) return 64'h999999;
        r = 0;
        x = v;
        for (int i = 0; i < 6; i++) begin
            r = r | ((x % 10) << (4 * i));
            x = x / 10;
        end
        return r;
    endfunction

    // Digit i is blank exactly when the value is below 10**i.
    function automatic longint lz_of(input longint v);
        longint r;
        longint p;
        if (v >= 1000000) return 0;
        r = 0;
        p = 10;
        for (int i = 1; i < 6; i++) begin
            if (v < p) r = r | (64'd1 << i);
            p = p * 10;
        end
        return r;
    endfunction

    task automatic check_outputs(input int c, input bit ev, input bit eb);
        check($sformatf("p%0d_c%0d_hz", phase, c), hz, exp_hz);
        check($sformatf("p%0d_c%0d_bcd", phase, c), bcd, exp_bcd);
        check($sformatf("p%0d_c%0d_overflow", phase, c), overflow, exp_ovf);
        check($sformatf("p%0d_c%0d_valid", phase, c), valid, ev);
        check($sformatf("p%0d_c%0d_busy", phase, c), busy, eb);
`ifdef FREQ_BLANK_LZ_EN
        check($sformatf("p%0d_c%0d_blank", phase, c), blank, exp_blank);
`endif
    endtask

    // mode: 0 random, 1 seven pulses, 2 edges at window boundaries, 3 quiet, 4 single edge at T.
    // fv >= 0 forces the edge counter to fv during the first terminal cycle; rst_c pulses reset.
    task automatic run_phase(input int mode, input int nwin, input longint fv, input int rst_c);
        int     c_end, c_drop, left;
        bit     alive, drv, prev, ev, eb;
        longint v;
        phase++;
        for (int i = 0; i < 8; i++) cnt[i] = 0;
        if (fv >= 0) cnt[0] = fv;
        c_end  = nwin * G + 35;
        c_drop = nwin * G + 10;
        alive  = 1'b1;
        prev   = 1'b0;
        drv    = 1'b0;
        left   = 0;
        sample_signal = 1'b0;
        run = 1'b0;
        repeat (4) @(posedge clk);
        #1 run = 1'b1;
        for (int c = 0; c <= c_end; c++) begin
            @(posedge clk);
            #1;
            if (c == rst_c + 1) rst_a_n = 1'b1;
            if (alive && c >= G && (c % G) == 0 && (c / G) <= nwin)
                exp_hz = sat(cnt[c / G - 1]);
            ev = 1'b0;
            if (alive && c >= G + 28 && ((c - 28) % G) == 0 && ((c - 28) / G) <= nwin) begin
                v         = sat(cnt[(c - 28) / G - 1]);
                exp_bcd   = to_bcd(v);
                exp_ovf   = (v >= 1000000) ? 1 : 0;
                exp_blank = lz_of(v);
                ev        = 1'b1;
            end
            eb = alive && c >= G && (c / G) <= nwin && (c % G) < 28;
            check_outputs(c, ev, eb);
            if (fv >= 0 && c == G - 1) begin
                force_val = fv[27:0];
                force dut.edge_cnt_r = force_val;
            end
            if (fv >= 0 && c == G) release dut.edge_cnt_r;
            if (c == c_drop) run = 1'b0;
            if (c == rst_c) begin
                run     = 1'b0;
                rst_a_n = 1'b0;
                #1;
                alive     = 1'b0;
                exp_hz    = 0;
                exp_bcd   = 0;
                exp_ovf   = 0;
                exp_blank = 6'b111110;
                check_outputs(c, 1'b0, 1'b0);
            end
            case (mode)
                1: drv = (c >= 5 && c < 75 && ((c - 5) % 10) < 2);
                2: drv = (c == 97 || c == 198);
                3: drv = 1'b0;
                4: drv = (c == 97);
                default: begin
                    if (left == 0) begin
                        drv  = !drv;
                        left = drv ? int'($urandom_range(3, 1)) : int'($urandom_range(4, 1));
                    end
                    left--;
                end
            endcase
            // A level driven now is seen as an edge two cycles later.
            if (drv && !prev && ((c + 2) / G) < 8) cnt[(c + 2) / G]++;
            prev = drv;
            sample_signal = drv;
        end
        run = 1'b0;
        sample_signal = 1'b0;
    endtask

    initial begin
        rst_a_n       = 1'b0;
        run           = 1'b0;
        sample_signal = 1'b0;
        force_val     = 28'd0;
        exp_hz        = 0;
        exp_bcd       = 0;
        exp_ovf       = 0;
        exp_blank     = 6'b111110;
        repeat (3) @(posedge clk);
        #1;
        check_outputs(-1, 1'b0, 1'b0);
        @(negedge clk);
        rst_a_n = 1'b1;

        run_phase(1, 1, -1, -1);
        run_phase(2, 3, -1, -1);
        run_phase(3, 1, 123456, -1);
        run_phase(3, 1, 1000000, -1);
        run_phase(3, 1, 999999, -1);
        run_phase(4, 1, CNT_MAX, -1);
        run_phase(0, 3, -1, -1);
        run_phase(0, 1, -1, G + 12);
        run_phase(0, 2, -1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/freq_gate_bcd_sequencer.md
Name: freq_gate_bcd_sequencer

Overview:
- Measurement sequencer for the frequency-meter datapath.
- Generates the gate window, counts rising edges of sample_signal, latches the count as hz, then runs an iterative double-dabble conversion to 6 BCD digits for the decoder_7_seg display chain.
- Replaces the combinational /10 %10 digit extraction with a 28-cycle shift-add-3 engine sequenced by a small FSM.

Parameters:
- GATE_CYCLES, 50_000_000, clk cycles per measurement window (1 s at 50 MHz); must be >= 32.
- BIN_W, 28, width of the edge counter and hz.
- DIGITS, 6, number of BCD digits output (fixed at 6 for this block).

Ports:
- clk  input  1  system clock
- rst_a_n  input  1  asynchronous active-low reset
- run  input  1  measurement enable
- sample_signal  input  1  asynchronous signal under test
- hz  output  28  latched edge count of last completed window
- bcd  output  24  {CM,DM,M,C,D,U} digits, 4 bits each, U in [3:0]
- valid  output  1  one-cycle pulse when bcd/overflow updated
- busy  output  1  conversion in progress
- overflow  output  1  last hz > 999_999

Behaviour:
- Reset: one clock, asynchronous, active-low. hz=0, bcd=0, valid=0, busy=0, overflow=0; all counters 0; FSMs in IDLE.
- Input conditioning: sample_signal passes a 2-flop synchronizer, then a rising-edge detector (edge = s2 & ~s3). Detection latency is 3 clk; pulses shorter than 1 clk may be missed.
- Gate FSM states: IDLE, GATE.
  - IDLE -> GATE when run=1.
  - GATE -> IDLE when run=0; gate and edge counters clear, hz is not updated.
- Gate counter runs 0..GATE_CYCLES-1. Terminal cycle T is gate_cnt==GATE_CYCLES-1.
  - An edge at T counts into the closing window.
  - At T+1: hz <= final count. Edge and gate counters restart at 0 with no dead cycle; an edge at T+1 counts into the new window.
- Edge counter saturates at 2^28-1 and does not wrap.
- Conversion FSM states: C_IDLE, C_SHIFT, C_DONE.
  - At T+1 it loads the latched count into the shift register and enters C_SHIFT; busy=1.
  - C_SHIFT runs 28 cycles, T+1..T+28. Each cycle: add 3 to every BCD nibble >= 5, then shift left 1 with the binary MSB entering bcd scratch bit 0.
  - C_DONE at T+29: bcd, overflow updated; valid=1 for exactly that cycle; busy=0; return to C_IDLE.
  - Gate-end-to-valid latency: 29 clk.
- Overflow: if latched count >= 1_000_000, bcd <= 24'h999999 and overflow=1; otherwise overflow=0. The scratch register is 24 bits; values below 1e6 never overflow it.
- Conversion always completes once started: run=0 mid-conversion does not abort it. A new gate end cannot arrive during conversion because GATE_CYCLES >= 32.
- hz and bcd hold their values between updates and while in IDLE.
- Reset mid-window or mid-conversion: immediate return to reset values. No partial result is published.

Optional Feature:
- Macro: FREQ_BLANK_LZ_EN.
- Defined:
  - Adds output blank [5:0]. Bit i=1 when digit i and all higher digits are 0.
  - Digit 0 (U) is never blanked.
  - Reset value 6'b111110.
  - Updated in the same C_DONE cycle as bcd.
  - On overflow, blank=0.
- Undefined: no blank port; no related logic.

Test Plan:
- GATE_CYCLES=100, run=1, 7 clean pulses (period 10 clk) inside first window -> at T+1 hz=7; at T+29 valid=1 for one cycle, bcd=24'h000007, overflow=0.
- GATE_CYCLES=100, preload edge counter via force to 123456 at T -> bcd=24'h123456, hz=123456, busy high for 28 cycles.
- GATE_CYCLES=100, force count 1_000_000 at T -> bcd=24'h999999, overflow=1; with FREQ_BLANK_LZ_EN, blank=0.
- Edge placed exactly at T and another at T+1 -> first counted in closing window (hz includes it), second counted in next window.
- Deassert run at T+10 (mid-conversion) -> valid still pulses at T+29 with correct bcd; no further hz update; gate counter stays 0.
- Assert rst_a_n=0 mid-conversion for 1 clk -> all outputs 0 immediately, no valid pulse; with FREQ_BLANK_LZ_EN blank=6'b111110; next run restarts a full window.
